// File: rtl/seven_segment_scan_capture_pkg.sv
// Shared constants for the 7-segment scan capture block and its bench monitors.
//   - Active-low segment codes {CA,CB,CC,CD,CE,CF,CG} for digits 0-9 and blank
//   - BCD codes used for a blank digit and for an unrecognised pattern
//   - FSM state encodings
//   - one_low(): true when exactly one active-low anode is asserted
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BLANK_BCD = 4'hF;
  localparam logic [3:0] BAD_BCD   = 4'hE;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETTLE   = 2'd1;
  localparam logic [1:0] ST_CAPTURED = 2'd2;

  function automatic logic one_low(input logic [7:0] anodes);
    logic [7:0] lo;
    lo = ~anodes;
    return (lo != 8'd0) && ((lo & (lo - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/seven_segment_scan_capture_if.sv
// Bundle of the scanned display pins and the rebuilt display value.
//   master: drives Enable/Err_clear/Anodes/Cathodes/DP, observes the outputs
//   slave : the capture block (reads the pins, drives Digits/DP_mask/flags)
interface seven_segment_scan_capture_if;
  logic        Enable;
  logic        Err_clear;
  logic [7:0]  Anodes;
  logic [6:0]  Cathodes;
  logic        DP;
  logic [31:0] Digits;
  logic [7:0]  DP_mask;
  logic        Frame_valid;
  logic        Seg_error;
  logic        Anode_error;

  modport master (
    output Enable, Err_clear, Anodes, Cathodes, DP,
    input  Digits, DP_mask, Frame_valid, Seg_error, Anode_error
  );

  modport slave (
    input  Enable, Err_clear, Anodes, Cathodes, DP,
    output Digits, DP_mask, Frame_valid, Seg_error, Anode_error
  );
endinterface

// File: rtl/seven_segment_scan_capture_decode.sv
// seg7_pattern_to_bcd: combinational decode of an active-low {CA..CG} pattern.
//   pattern in  7  active-low segment lines
//   bad     out 1  pattern is neither 0-9 nor blank
//   bcd     out 4  decoded digit, BLANK_BCD for blank, BAD_BCD when bad
module seg7_pattern_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       bad,
  output logic [3:0] bcd
);

  always_comb begin
    bad = 1'b0;
    case (pattern)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: bcd = BLANK_BCD;
      default: begin
        bcd = BAD_BCD;
        bad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_capture.sv
// Rebuilds the 8-digit value shown on a multiplexed 7-segment display by watching
// its anode/cathode/DP pins.
//   Clock_100MHz in  system clock
//   Clear_n      in  asynchronous active-low reset
//   bus (slave)      Enable, Err_clear, Anodes, Cathodes, DP in;
//                    Digits, DP_mask, Frame_valid, Seg_error, Anode_error out
module seven_segment_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic                          Clock_100MHz,
  input  logic                          Clear_n,
  seven_segment_scan_capture_if.slave   bus
);

  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_CAP = CNT_W'(STABLE_CYCLES - 1);

  // Synced pin word: {Anodes, Cathodes, DP}; all-ones is the display-off pattern.
  logic [15:0]      sync1_q, sync1_d, sync_q, prev_q;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [1:0]       state_q, state_d;
  logic [7:0][3:0]  shadow_q, shadow_d;
  logic [7:0]       dpm_q, dpm_d, seen_q, seen_d, dp_mask_q, dp_mask_d;
  logic [31:0]      digits_q, digits_d;
  logic             frame_valid_q, frame_valid_d;
  logic             seg_err_q, seg_err_d, anode_err_q, anode_err_d;

  logic [7:0] s_an;
  logic [6:0] s_cath;
  logic       s_dp_n, same, any_low, capture, dec_bad;
  logic [3:0] dec_bcd;

  assign s_an   = sync_q[15:8];
  assign s_cath = sync_q[7:1];
  assign s_dp_n = sync_q[0];

  seg7_pattern_to_bcd u_dec (
    .pattern (s_cath),
    .bad     (dec_bad),
    .bcd     (dec_bcd)
  );

  always_comb begin
    sync1_d       = {bus.Anodes, bus.Cathodes, bus.DP};
    same          = (sync_q == prev_q);
    any_low       = (s_an != 8'hFF);
    state_d       = state_q;
    shadow_d      = shadow_q;
    dpm_d         = dpm_q;
    seen_d        = seen_q;
    digits_d      = digits_q;
    dp_mask_d     = dp_mask_q;
    frame_valid_d = 1'b0;
    capture       = 1'b0;
    seg_err_d     = bus.Err_clear ? 1'b0 : seg_err_q;
    anode_err_d   = bus.Err_clear ? 1'b0 : anode_err_q;

    if (!same)                   dwell_d = '0;
    else if (dwell_q == DWELL_MAX) dwell_d = dwell_q;
    else                         dwell_d = dwell_q + CNT_W'(1);

    if (!bus.Enable) begin
      state_d = ST_IDLE;
      dwell_d = '0;
      seen_d  = '0;
    end else begin
      case (state_q)
        // Any low anode starts a dwell, so overlapping anodes reach the error check.
        ST_IDLE: if (any_low) state_d = ST_SETTLE;
        // dwell_d reaching STABLE_CYCLES-1 means the pattern was held STABLE_CYCLES samples.
        ST_SETTLE: begin
          if (!same) begin
            state_d = any_low ? ST_SETTLE : ST_IDLE;
          end else if (dwell_d == DWELL_CAP) begin
            state_d = ST_CAPTURED;
            if (one_low(s_an)) capture     = 1'b1;
            else               anode_err_d = 1'b1;
          end
        end
        ST_CAPTURED: if (!same) state_d = any_low ? ST_SETTLE : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (capture) begin
      for (int i = 0; i < 8; i++) begin
        if (!s_an[i]) begin
          shadow_d[i] = dec_bcd;
          dpm_d[i]    = ~s_dp_n;
          seen_d[i]   = 1'b1;
        end
      end
      if (dec_bad) seg_err_d = 1'b1;
      // Frame completes on the capture that fills the bitmap.
      if (seen_d == 8'hFF) begin
        digits_d      = shadow_d;
        dp_mask_d     = dpm_d;
        frame_valid_d = 1'b1;
        seen_d        = '0;
      end
    end
  end

  always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
    if (!Clear_n) begin
      sync1_q       <= '1;
      sync_q        <= '1;
      prev_q        <= '1;
      dwell_q       <= '0;
      state_q       <= ST_IDLE;
      shadow_q      <= '0;
      dpm_q         <= '0;
      seen_q        <= '0;
      digits_q      <= '0;
      dp_mask_q     <= '0;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      anode_err_q   <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync_q        <= sync1_q;
      prev_q        <= sync_q;
      dwell_q       <= dwell_d;
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      dpm_q         <= dpm_d;
      seen_q        <= seen_d;
      digits_q      <= digits_d;
      dp_mask_q     <= dp_mask_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      anode_err_q   <= anode_err_d;
    end
  end

  assign bus.Digits      = digits_q;
  assign bus.DP_mask     = dp_mask_q;
  assign bus.Frame_valid = frame_valid_q;
  assign bus.Seg_error   = seg_err_q;
  assign bus.Anode_error = anode_err_q;

endmodule

// File: tb/tb_seven_segment_scan_capture.sv
// Directed bench for seven_segment_scan_capture: frame table plus corner sequences.
module tb_seven_segment_scan_capture;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   fv_total = 0;
  int   base;

  always #5 clk = ~clk;

  seven_segment_scan_capture_if bus();

  seven_segment_scan_capture #(.STABLE_CYCLES(16), .CNT_W(8)) dut (
    .Clock_100MHz (clk),
    .Clear_n      (clear_n),
    .bus          (bus)
  );

  always @(negedge clk) if (bus.Frame_valid === 1'b1) fv_total++;

  // vals nibble i: 0-9 digit, 4'hA blank, 4'hB illegal pattern
  typedef struct {
    logic [31:0] vals;
    logic [7:0]  dp_low;
    bit          desc;
    logic [31:0] exp_dig;
    logic [7:0]  exp_dpm;
    logic        exp_seg;
  } frame_t;

  frame_t frames [4];

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      4'hA: return 7'b1111111;
      default: return 7'b1111110;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic show(input int idx, input logic [3:0] v, input bit dp_low, input int n);
    bus.Anodes   = ~(8'(1) << idx);
    bus.Cathodes = seg_of(v);
    bus.DP       = ~dp_low;
    repeat (n) @(negedge clk);
  endtask

  task automatic off(input int n);
    bus.Anodes   = 8'hFF;
    bus.Cathodes = 7'h7F;
    bus.DP       = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input int lo, input int hi, input logic [3:0] v);
    for (int i = lo; i <= hi; i++) show(i, v, 1'b0, 20);
    off(4);
  endtask

  task automatic err_clear_pulse();
    bus.Err_clear = 1'b1;
    @(negedge clk);
    bus.Err_clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    frames[0] = '{32'h87654321, 8'h00, 1'b0, 32'h87654321, 8'h00, 1'b0};
    frames[1] = '{32'h01234567, 8'h81, 1'b0, 32'h01234567, 8'h81, 1'b0};
    frames[2] = '{32'h88888888, 8'hFF, 1'b1, 32'h88888888, 8'hFF, 1'b0};
    frames[3] = '{32'h99A9B999, 8'h00, 1'b0, 32'h99F9E999, 8'h00, 1'b1};

    bus.Enable = 1'b1;
    bus.Err_clear = 1'b0;
    bus.Anodes = 8'hFF;
    bus.Cathodes = 7'h7F;
    bus.DP = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_digits", bus.Digits, 32'h0);
    chk("rst_dpmask", {24'h0, bus.DP_mask}, 32'h0);
    chk("rst_fv", {31'h0, bus.Frame_valid}, 32'h0);
    chk("rst_segerr", {31'h0, bus.Seg_error}, 32'h0);
    chk("rst_anerr", {31'h0, bus.Anode_error}, 32'h0);
    clear_n = 1'b1;
    off(3);

    // Table of full frames
    for (int f = 0; f < 4; f++) begin
      base = fv_total;
      for (int k = 0; k < 8; k++) begin
        int i;
        i = frames[f].desc ? 7 - k : k;
        show(i, frames[f].vals[4*i +: 4], frames[f].dp_low[i], 20);
      end
      off(4);
      chk($sformatf("f%0d_count", f), fv_total - base, 1);
      chk($sformatf("f%0d_digits", f), bus.Digits, frames[f].exp_dig);
      chk($sformatf("f%0d_dpmask", f), {24'h0, bus.DP_mask}, {24'h0, frames[f].exp_dpm});
      chk($sformatf("f%0d_segerr", f), {31'h0, bus.Seg_error}, {31'h0, frames[f].exp_seg});
      chk($sformatf("f%0d_anerr", f), {31'h0, bus.Anode_error}, 32'h0);
    end

    // Seg_error is sticky until Err_clear
    off(10);
    chk("segerr_sticky", {31'h0, bus.Seg_error}, 32'h1);
    err_clear_pulse();
    chk("segerr_cleared", {31'h0, bus.Seg_error}, 32'h0);

    // Dwell one short of the threshold does not capture; exactly the threshold does
    base = fv_total;
    show(0, 4'd5, 1'b0, 15);
    off(4);
    scan(1, 7, 4'd1);
    chk("short_dwell_count", fv_total - base, 0);
    chk("short_dwell_digits", bus.Digits, 32'h99F9E999);
    show(0, 4'd5, 1'b0, 16);
    off(4);
    chk("exact_dwell_count", fv_total - base, 1);
    chk("exact_dwell_digits", bus.Digits, 32'h11111115);

    // Two anodes low: error, no capture, bitmap unchanged
    bus.Anodes = 8'hFC;
    bus.Cathodes = seg_of(4'd3);
    bus.DP = 1'b1;
    repeat (20) @(negedge clk);
    off(4);
    chk("multi_anerr", {31'h0, bus.Anode_error}, 32'h1);
    base = fv_total;
    scan(2, 7, 4'd2);
    chk("multi_nocap", fv_total - base, 0);
    scan(0, 1, 4'd6);
    chk("multi_frame_count", fv_total - base, 1);
    chk("multi_frame_digits", bus.Digits, 32'h22222266);
    err_clear_pulse();
    chk("anerr_cleared", {31'h0, bus.Anode_error}, 32'h0);

    // Enable drop mid-frame discards the partial bitmap
    base = fv_total;
    scan(0, 3, 4'd7);
    bus.Enable = 1'b0;
    off(3);
    bus.Enable = 1'b1;
    off(2);
    scan(4, 7, 4'd7);
    chk("enable_nofv", fv_total - base, 0);
    chk("enable_hold", bus.Digits, 32'h22222266);
    scan(0, 3, 4'd7);
    chk("enable_refill", fv_total - base, 1);
    chk("enable_digits", bus.Digits, 32'h77777777);

    // Reset mid-frame
    scan(0, 4, 4'd3);
    clear_n = 1'b0;
    @(negedge clk);
    chk("midrst_digits", bus.Digits, 32'h0);
    chk("midrst_dpmask", {24'h0, bus.DP_mask}, 32'h0);
    chk("midrst_fv", {31'h0, bus.Frame_valid}, 32'h0);
    clear_n = 1'b1;
    off(4);
    base = fv_total;
    for (int i = 0; i < 8; i++) show(i, 4'd4, (i == 2), 20);
    off(4);
    chk("postrst_count", fv_total - base, 1);
    chk("postrst_digits", bus.Digits, 32'h44444444);
    chk("postrst_dpmask", {24'h0, bus.DP_mask}, 32'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
